// File: rtl/kgp_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CKSUM state exists only when BOOT_CKSUM_EN is defined.
package kgp_boot_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite,
`ifdef BOOT_CKSUM_EN
    StCksum,
`endif
    StDone,
    StErr
  } boot_state_e;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_byte(boot_state_e s);
`ifdef BOOT_CKSUM_EN
    return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StCksum);
`else
    return (s == StLenHi) || (s == StLenLo) || (s == StData);
`endif
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted stream bytes MSB-first into a 32-bit word and pulses
// word_ready the cycle after the last byte of a word is taken.
module boot_word_packer
  import kgp_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_ready
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= accept && (cnt_q == LastByte);
      if (accept) begin
        word_q <= {word_q[23:0], din};
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

  assign word       = word_q;
  assign byte_cnt   = cnt_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed big-endian program into instruction memory and
// holds the core in reset until it lands. Optional trailing XOR check: BOOT_CKSUM_EN.
module imem_boot_loader
  import kgp_boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned    TmoW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W:0] MaxWords = (LEN_W + 1)'(2 ** ADDR_W);
  localparam logic [1:0]     LastByte = 2'(BYTES_PER_WORD - 1);

  boot_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rx_ready_q, core_reset_q, busy_q, done_q, error_q;
`ifdef BOOT_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic             accept;
  logic             pack_clear;
  logic [1:0]       byte_cnt;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W:0]   wl_next;

  assign accept   = rx_valid && rx_ready_q;
  assign len_full = {len_q[LEN_W-1:8], rx_data};
  assign wl_next  = (LEN_W + 1)'(wl_q) + (LEN_W + 1)'(1);

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .accept     (accept && (state_q == StData)),
    .din        (rx_data),
    .word       (imem_wdata),
    .byte_cnt   (byte_cnt),
    .word_ready (imem_we)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wl_d       = wl_q;
    pack_clear = 1'b0;
`ifdef BOOT_CKSUM_EN
    cksum_d    = cksum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenHi;
          len_d      = '0;
          wl_d       = '0;
          pack_clear = 1'b1;
`ifdef BOOT_CKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[LEN_W-1:8] = rx_data;
          state_d          = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0) begin
`ifdef BOOT_CKSUM_EN
            state_d = StCksum;
`else
            state_d = StDone;
`endif
          end else if ({1'b0, len_full} > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
`ifdef BOOT_CKSUM_EN
          cksum_d = cksum_q ^ rx_data;
`endif
          if (byte_cnt == LastByte) state_d = StWrite;
        end
      end
      StWrite: begin
        wl_d = wl_q + 1'b1;
        if (wl_next < {1'b0, len_q}) begin
          state_d = StData;
        end else begin
`ifdef BOOT_CKSUM_EN
          state_d = StCksum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BOOT_CKSUM_EN
      StCksum: begin
        if (accept) state_d = (rx_data == cksum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StErr;
    endcase

    // Stream stalled too long while waiting for a byte.
    if (accepts_byte(state_q) && !accept && (tmo_q == TmoLast)) state_d = StErr;

    if ((state_d != state_q) || accept || !accepts_byte(state_q)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      wl_q         <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      rx_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wl_q       <= wl_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= accepts_byte(state_d);
      busy_q     <= !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StErr);
      // Release the core only once DONE has been held for a full cycle.
      core_reset_q <= !((state_d == StDone) && (state_q == StDone));
      if (state_d == StWrite) addr_q <= wl_q[ADDR_W-1:0];
    end
  end

`ifdef BOOT_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end
`endif

  assign rx_ready     = rx_ready_q;
  assign imem_addr    = addr_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader: expected writes and
// final status come from the stream contents; a monitor checks every cycle.
module tb_imem_boot_loader;

  localparam int ADDR_W      = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int CAP         = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, imem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_wr[$];
  int          total = 0;
  int          bad = 0;
  int          wr_seen = 0;
  logic        done_prev = 1'b0;
  logic [31:0] wbuf[0:CAP];
  logic [7:0]  sbuf[0:4*CAP+8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: writes against the scoreboard, plus status rules.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_seen   = 0;
        done_prev = 1'b0;
      end else begin
        check("words_loaded_track", 64'(words_loaded), 64'(wr_seen));
        check("core_reset_rule", 64'(core_reset), 64'(!(done && done_prev)));
        check("status_exclusive", 64'($countones({done, error, busy}) <= 1), 64'd1);
        check("ready_only_busy", 64'(rx_ready && !busy), 64'd0);
        if (imem_we) begin
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0h data %0h", imem_addr, imem_wdata);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("imem_addr", 64'(imem_addr), 64'(e.addr));
            check("imem_wdata", 64'(imem_wdata), 64'(e.data));
          end
          wr_seen++;
        end
        if (start && !busy) wr_seen = 0;
        done_prev = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit poke_start);
    int  n;
    bit  acc;
    int  gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = poke_start;
    n        = 0;
    forever begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL handshake_stuck: byte %0h never accepted", b);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_buf(input int nb, input int poke_idx);
    for (int i = 0; i < nb; i++) send_byte(sbuf[i], i == poke_idx);
  endtask

  // Builds the stream for n words held in wbuf and queues the expected writes.
  task automatic build_load(input int n, input bit corrupt, output int nb);
    logic [7:0] x;
    logic [7:0] b;
    x       = 8'h00;
    sbuf[0] = 8'(n >> 8);
    sbuf[1] = 8'(n);
    nb      = 2;
    exp_wr.delete();
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back('{addr: ADDR_W'(i), data: wbuf[i]});
        for (int k = 3; k >= 0; k--) begin
          b        = 8'(wbuf[i] >> (8 * k));
          x        = x ^ b;
          sbuf[nb] = b;
          nb++;
        end
      end
`ifdef BOOT_CKSUM_EN
      sbuf[nb] = corrupt ? (x ^ 8'h01) : x;
      nb++;
`endif
    end
  endtask

  task automatic finish_check(input bit exp_ok, input int exp_wl, input int bound);
    int c;
    c = 0;
    @(negedge clk);
    while (!(done || error) && c < bound) begin
      @(negedge clk);
      c++;
    end
    if (!(done || error)) begin
      total++;
      bad++;
      $display("FAIL outcome_timeout: no done/error within %0d cycles", bound);
    end
    check("done", 64'(done), 64'(exp_ok));
    check("error", 64'(error), 64'(!exp_ok));
    check("words_loaded_final", 64'(words_loaded), 64'(exp_wl));
    check("writes_pending", 64'(exp_wr.size()), 64'd0);
    @(negedge clk);
    check("core_reset_after", 64'(core_reset), 64'(!exp_ok));
    tick();
  endtask

  task automatic random_load(input int n, input bit corrupt, input int poke_idx);
    int  nb;
    bit  ok;
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    pulse_start();
    build_load(n, corrupt, nb);
    send_buf(nb, poke_idx);
    ok = (n <= CAP);
`ifdef BOOT_CKSUM_EN
    if (corrupt) ok = 1'b0;
`endif
    finish_check(ok, (n <= CAP) ? n : 0, 10);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int nb;
    int stall;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    tick();

    // Literal two-word program.
    pulse_start();
    exp_wr.delete();
    exp_wr.push_back('{addr: 8'd0, data: 32'h2001_0005});
    exp_wr.push_back('{addr: 8'd1, data: 32'h8C22_0004});
    sbuf[0] = 8'h00; sbuf[1] = 8'h02;
    sbuf[2] = 8'h20; sbuf[3] = 8'h01; sbuf[4] = 8'h00; sbuf[5] = 8'h05;
    sbuf[6] = 8'h8C; sbuf[7] = 8'h22; sbuf[8] = 8'h00; sbuf[9] = 8'h04;
    nb = 10;
`ifdef BOOT_CKSUM_EN
    sbuf[10] = 8'h8E;
    nb = 11;
`endif
    send_buf(nb, -1);
    finish_check(1'b1, 2, 10);

    // Zero-length program.
    random_load(0, 1'b0, -1);
    // Over capacity by one: rejected right after the length.
    random_load(CAP + 1, 1'b0, -1);
    // Exactly full capacity.
    random_load(CAP, 1'b0, -1);

    // Stall mid-word until the timeout fires.
    pulse_start();
    exp_wr.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stall = 0;
    @(negedge clk);
    while (!error && stall < TIMEOUT_CYC + 20) begin
      stall++;
      @(negedge clk);
    end
    check("timeout_cycles", 64'(stall), 64'(TIMEOUT_CYC));
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_core_reset", 64'(core_reset), 64'd1);
    tick();
    random_load(3, 1'b0, -1);

`ifdef BOOT_CKSUM_EN
    wbuf[0] = 32'h0102_0304;
    pulse_start();
    build_load(1, 1'b0, nb);
    check("cksum_literal", 64'(sbuf[6]), 64'h04);
    send_buf(nb, -1);
    finish_check(1'b1, 1, 10);
    pulse_start();
    build_load(1, 1'b1, nb);
    check("cksum_bad_literal", 64'(sbuf[6]), 64'h05);
    send_buf(nb, -1);
    finish_check(1'b0, 1, 10);
`endif

    // Reset during word 3 of a 5-word load, with start asserted alongside.
    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    pulse_start();
    build_load(5, 1'b0, nb);
    send_buf(12, -1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_values("midload");
    tick();
    pulse_start();
    build_load(5, 1'b0, nb);
    send_buf(nb, -1);
    finish_check(1'b1, 5, 10);

    // Random programs; a stray start pulse mid-stream must be ignored.
    for (int t = 0; t < 8; t++) begin
      int  n;
      bit  corrupt;
      n       = $urandom_range(1, 9);
      corrupt = ($urandom_range(0, 3) == 0);
      random_load(n, corrupt, (t % 2 == 0) ? $urandom_range(3, 4 * n) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
